// File: rtl/frame_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : frame_sequencer
//  Description : Turns the slow ~60 Hz frame tick from the clock divider into
//                one handshaked render frame per rising edge, in the clk_50mhz
//                domain. Each frame runs CLEAR -> DRAW -> SWAP. Tick edges
//                that arrive while a frame is still in flight are dropped and
//                counted.
//  Option      : FRAME_TIMEOUT_EN (define) - aborts a frame that stays in
//                CLEAR or DRAW for TIMEOUT_CYC cycles without its done input.
//                When undefined, the FSM waits indefinitely and timeout is 0.
//  Ports       : clk_50mhz   - system clock
//                rst         - asynchronous reset, active-high
//                tick_in     - frame tick, asynchronous to clk_50mhz
//                clear_done  - engine reports that the clear phase is done
//                draw_done   - engine reports that the draw phase is done
//                frame_start - 1-cycle pulse when a frame begins
//                clear_req   - high for the whole CLEAR state
//                draw_req    - high for the whole DRAW state
//                buf_swap    - 1-cycle pulse in SWAP state
//                busy        - high whenever a frame is in progress
//                frame_cnt   - completed frames (wraps)
//                drop_cnt    - dropped ticks (saturates)
//                overrun     - sticky, set on first dropped tick
//                timeout     - sticky, set on a timeout abort
//  Revision    : 1.0 - initial release
// ============================================================================
module frame_sequencer #(
  parameter int FRAME_CNT_W = 16,
  parameter int DROP_CNT_W  = 8,
  parameter int TIMEOUT_CYC = 1_000_000
) (
  input  logic                   clk_50mhz,
  input  logic                   rst,
  input  logic                   tick_in,
  input  logic                   clear_done,
  input  logic                   draw_done,
  output logic                   frame_start,
  output logic                   clear_req,
  output logic                   draw_req,
  output logic                   buf_swap,
  output logic                   busy,
  output logic [FRAME_CNT_W-1:0] frame_cnt,
  output logic [DROP_CNT_W-1:0]  drop_cnt,
  output logic                   overrun,
  output logic                   timeout
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_DRAW  = 2'd2,
    ST_SWAP  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Three-flop synchroniser; s3 keeps the previous synchronised level so
  // only the rising edge of the tick is detected.
  logic r_tick_s1, r_tick_s2, r_tick_s3;
  logic w_tick_rise;
  logic w_drop;
  logic w_timer_exp;
  logic w_abort;

  logic w_frame_start_nxt;
  logic w_clear_req_nxt;
  logic w_draw_req_nxt;
  logic w_buf_swap_nxt;
  logic w_busy_nxt;

  assign w_tick_rise = r_tick_s2 & ~r_tick_s3;
  // A rise seen while a frame is in flight is never queued.
  assign w_drop      = w_tick_rise && (r_state != ST_IDLE);

  always_ff @(posedge clk_50mhz or posedge rst) begin
    if (rst) begin
      r_tick_s1 <= 1'b0;
      r_tick_s2 <= 1'b0;
      r_tick_s3 <= 1'b0;
    end else begin
      r_tick_s1 <= tick_in;
      r_tick_s2 <= r_tick_s1;
      r_tick_s3 <= r_tick_s2;
    end
  end

  // Next-state and next-output decode. Each done input is only looked at in
  // its own state; a done arriving together with timer expiry wins.
  always_comb begin
    w_state_nxt       = r_state;
    w_abort           = 1'b0;
    w_frame_start_nxt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_tick_rise) begin
          w_state_nxt       = ST_CLEAR;
          w_frame_start_nxt = 1'b1;
        end
      end
      ST_CLEAR: begin
        if (clear_done) begin
          w_state_nxt = ST_DRAW;
        end else if (w_timer_exp) begin
          w_state_nxt = ST_IDLE;
          w_abort     = 1'b1;
        end
      end
      ST_DRAW: begin
        if (draw_done) begin
          w_state_nxt = ST_SWAP;
        end else if (w_timer_exp) begin
          w_state_nxt = ST_IDLE;
          w_abort     = 1'b1;
        end
      end
      ST_SWAP: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
    w_clear_req_nxt = (w_state_nxt == ST_CLEAR);
    w_draw_req_nxt  = (w_state_nxt == ST_DRAW);
    w_buf_swap_nxt  = (w_state_nxt == ST_SWAP);
    w_busy_nxt      = (w_state_nxt != ST_IDLE);
  end

  // State and all outputs are registered so the engine sees clean levels.
  always_ff @(posedge clk_50mhz or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      frame_start <= 1'b0;
      clear_req   <= 1'b0;
      draw_req    <= 1'b0;
      buf_swap    <= 1'b0;
      busy        <= 1'b0;
      frame_cnt   <= '0;
      drop_cnt    <= '0;
      overrun     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      frame_start <= w_frame_start_nxt;
      clear_req   <= w_clear_req_nxt;
      draw_req    <= w_draw_req_nxt;
      buf_swap    <= w_buf_swap_nxt;
      busy        <= w_busy_nxt;
      // A frame counts as completed when SWAP is left; wraps silently.
      if (r_state == ST_SWAP) begin
        frame_cnt <= frame_cnt + 1'b1;
      end
      if (w_drop) begin
        overrun <= 1'b1;
        if (drop_cnt != {DROP_CNT_W{1'b1}}) begin
          drop_cnt <= drop_cnt + 1'b1;
        end
      end
    end
  end

`ifdef FRAME_TIMEOUT_EN
  localparam int c_TMR_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [c_TMR_W-1:0] c_TMR_LAST = c_TMR_W'(TIMEOUT_CYC - 1);

  logic [c_TMR_W-1:0] r_timer;

  assign w_timer_exp = (r_timer == c_TMR_LAST);

  // Restarts from zero on every state change, so it is zero on the first
  // cycle of both CLEAR and DRAW; it never passes c_TMR_LAST because the
  // FSM leaves the state on that cycle.
  always_ff @(posedge clk_50mhz or posedge rst) begin
    if (rst) begin
      r_timer <= '0;
    end else if (w_state_nxt != r_state) begin
      r_timer <= '0;
    end else if ((r_state == ST_CLEAR) || (r_state == ST_DRAW)) begin
      r_timer <= r_timer + 1'b1;
    end
  end

  always_ff @(posedge clk_50mhz or posedge rst) begin
    if (rst) begin
      timeout <= 1'b0;
    end else if (w_abort) begin
      timeout <= 1'b1;
    end
  end
`else
  assign w_timer_exp = 1'b0;
  assign timeout     = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_frame_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_frame_sequencer
//  Description : Self-checking bench for frame_sequencer. A frame-level model
//                predicts every output each cycle; directed scenarios add
//                hand-computed checks on latency, phase lengths and counters.
//                Honours FRAME_TIMEOUT_EN in the same way as the design.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_frame_sequencer;

  localparam int FCW = 4;
  localparam int DCW = 8;
  localparam int TOC = 16;
`ifdef FRAME_TIMEOUT_EN
  localparam bit TO_ON = 1'b1;
`else
  localparam bit TO_ON = 1'b0;
`endif

  logic           clk_50mhz  = 1'b0;
  logic           rst        = 1'b1;
  logic           tick_in    = 1'b0;
  logic           clear_done = 1'b0;
  logic           draw_done  = 1'b0;
  logic           frame_start, clear_req, draw_req, buf_swap, busy;
  logic [FCW-1:0] frame_cnt;
  logic [DCW-1:0] drop_cnt;
  logic           overrun, timeout;

  always #5 clk_50mhz = ~clk_50mhz;

  frame_sequencer #(
    .FRAME_CNT_W (FCW),
    .DROP_CNT_W  (DCW),
    .TIMEOUT_CYC (TOC)
  ) dut (
    .clk_50mhz   (clk_50mhz),
    .rst         (rst),
    .tick_in     (tick_in),
    .clear_done  (clear_done),
    .draw_done   (draw_done),
    .frame_start (frame_start),
    .clear_req   (clear_req),
    .draw_req    (draw_req),
    .buf_swap    (buf_swap),
    .busy        (busy),
    .frame_cnt   (frame_cnt),
    .drop_cnt    (drop_cnt),
    .overrun     (overrun),
    .timeout     (timeout)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- frame-level model ----------------
  // phase: 0 idle, 1 clearing, 2 drawing, 3 swapping
  int m_phase  = 0;
  int m_frames = 0;
  int m_drops  = 0;
  int m_tmr    = 0;
  bit m_start  = 0;
  bit m_ovr    = 0;
  bit m_to     = 0;
  bit tin [3]  = '{0, 0, 0};  // tick_in sampled 1, 2, 3 edges ago

  always @(posedge clk_50mhz or posedge rst) begin : mdl
    bit rise;
    if (rst) begin
      m_phase = 0; m_frames = 0; m_drops = 0; m_tmr = 0;
      m_start = 0; m_ovr = 0; m_to = 0;
      tin = '{0, 0, 0};
    end else begin
      // The tick takes two edges to cross the synchroniser.
      rise = tin[1] && !tin[2];
      tin[2] = tin[1]; tin[1] = tin[0]; tin[0] = tick_in;
      m_start = 0;
      if (rise && m_phase != 0) begin
        if (m_drops < (1 << DCW) - 1) m_drops++;
        m_ovr = 1;
      end
      case (m_phase)
        0: if (rise) begin m_phase = 1; m_start = 1; m_tmr = 0; end
        1: if (clear_done) begin m_phase = 2; m_tmr = 0; end
           else if (TO_ON && m_tmr == TOC - 1) begin m_phase = 0; m_to = 1; end
           else m_tmr++;
        2: if (draw_done) begin m_phase = 3; m_tmr = 0; end
           else if (TO_ON && m_tmr == TOC - 1) begin m_phase = 0; m_to = 1; end
           else m_tmr++;
        default: begin m_phase = 0; m_frames = (m_frames + 1) % (1 << FCW); end
      endcase
    end
  end

  // ---------------- per-cycle compare ----------------
  int n_start = 0, n_clear = 0, n_draw = 0, n_swap = 0;

  always @(posedge clk_50mhz) begin
    #1;
    check("frame_start", frame_start, m_start);
    check("clear_req",   clear_req,   m_phase == 1);
    check("draw_req",    draw_req,    m_phase == 2);
    check("buf_swap",    buf_swap,    m_phase == 3);
    check("busy",        busy,        m_phase != 0);
    check("frame_cnt",   frame_cnt,   m_frames);
    check("drop_cnt",    drop_cnt,    m_drops);
    check("overrun",     overrun,     m_ovr);
    check("timeout",     timeout,     m_to);
    n_start += int'(frame_start);
    n_clear += int'(clear_req);
    n_draw  += int'(draw_req);
    n_swap  += int'(buf_swap);
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_reset();
    @(negedge clk_50mhz) rst = 1'b1;
    repeat (2) @(negedge clk_50mhz);
    rst = 1'b0;
  endtask

  task automatic tick_pulse(input int hi);
    @(negedge clk_50mhz) tick_in = 1'b1;
    repeat (hi) @(negedge clk_50mhz);
    tick_in = 1'b0;
  endtask

  // which: 0 clear_req, 1 draw_req, 2 idle (busy low)
  task automatic wait_for(input string name, input int which, input int budget);
    logic c;
    c = 1'b0;
    for (int i = 0; i < budget; i++) begin
      c = (which == 0) ? clear_req : (which == 1) ? draw_req : !busy;
      if (c) break;
      @(negedge clk_50mhz);
    end
    check(name, c, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int b_start, b_clear, b_draw, b_swap, lat, c;

    // ---- 1: minimum frame, done inputs tied high ----
    do_reset();
    check("reset_frame_cnt", frame_cnt, 0);
    check("reset_busy", busy, 0);
    clear_done = 1'b1; draw_done = 1'b1;
    b_start = n_start; b_clear = n_clear; b_draw = n_draw; b_swap = n_swap;
    @(negedge clk_50mhz) tick_in = 1'b1;
    lat = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk_50mhz); #1;
      lat++;
      if (frame_start) break;
    end
    check("t1_start_latency", lat, 3);
    repeat (2) @(negedge clk_50mhz);
    tick_in = 1'b0;
    wait_for("t1_idle", 2, 20);
    repeat (2) @(negedge clk_50mhz);
    check("t1_frame_cnt", frame_cnt, 1);
    check("t1_starts", n_start - b_start, 1);
    check("t1_clear_cycles", n_clear - b_clear, 1);
    check("t1_draw_cycles", n_draw - b_draw, 1);
    check("t1_swaps", n_swap - b_swap, 1);

    // ---- 2: clear_done after 10 cycles, draw_done after 20 ----
    clear_done = 1'b0; draw_done = 1'b0;
    b_clear = n_clear; b_draw = n_draw; b_swap = n_swap;
    tick_pulse(1);
    wait_for("t2_clear", 0, 10);
    repeat (9) @(negedge clk_50mhz);
    clear_done = 1'b1;
    @(negedge clk_50mhz) clear_done = 1'b0;
    repeat (19) @(negedge clk_50mhz);
    draw_done = 1'b1;
    @(negedge clk_50mhz) draw_done = 1'b0;
    wait_for("t2_idle", 2, 10);
    repeat (2) @(negedge clk_50mhz);
`ifndef FRAME_TIMEOUT_EN
    check("t2_clear_cycles", n_clear - b_clear, 10);
    check("t2_draw_cycles", n_draw - b_draw, 20);
    check("t2_swaps", n_swap - b_swap, 1);
    check("t2_frame_cnt", frame_cnt, 2);
`endif

    // ---- 3: tick while drawing is dropped; saturation ----
    do_reset();
    b_start = n_start; b_swap = n_swap;
    tick_pulse(1);
    wait_for("t3_clear", 0, 10);
    clear_done = 1'b1;
    @(negedge clk_50mhz) clear_done = 1'b0;
    tick_pulse(1);
    repeat (4) @(negedge clk_50mhz);
    check("t3_drop_cnt", drop_cnt, 1);
    check("t3_overrun", overrun, 1);
    check("t3_still_drawing", draw_req, 1);
    draw_done = 1'b1;
    @(negedge clk_50mhz) draw_done = 1'b0;
    wait_for("t3_idle", 2, 10);
    repeat (4) @(negedge clk_50mhz);
    check("t3_frame_cnt", frame_cnt, 1);
    check("t3_starts", n_start - b_start, 1);
    check("t3_swaps", n_swap - b_swap, 1);
    repeat (400) begin
      tick_pulse(1);
      repeat (3) @(negedge clk_50mhz);
    end
    check("t3_drop_sat", drop_cnt, 255);
    check("t3_overrun_sticky", overrun, 1);
    clear_done = 1'b1; draw_done = 1'b1;
    wait_for("t3_idle2", 2, 10);
    repeat (2) @(negedge clk_50mhz);

    // ---- 4: asynchronous reset in the middle of DRAW ----
    draw_done = 1'b0;
    tick_pulse(1);
    wait_for("t4_draw", 1, 10);
    #2 rst = 1'b1;
    #1;
    check("t4_draw_req_async", draw_req, 0);
    check("t4_busy_async", busy, 0);
    check("t4_frame_cnt_async", frame_cnt, 0);
    check("t4_overrun_async", overrun, 0);
    check("t4_drop_cnt_async", drop_cnt, 0);
    @(negedge clk_50mhz) rst = 1'b0;
    draw_done = 1'b1;
    b_swap = n_swap;
    tick_pulse(1);
    repeat (10) @(negedge clk_50mhz);
    check("t4_frame_cnt_after", frame_cnt, 1);
    check("t4_swaps_after", n_swap - b_swap, 1);

    // ---- 5: frame counter wraps with a 4-bit counter ----
    do_reset();
    b_swap = n_swap;
    repeat (17) begin
      tick_pulse(1);
      repeat (8) @(negedge clk_50mhz);
    end
    check("t5_frame_cnt_wrap", frame_cnt, 1);
    check("t5_swaps", n_swap - b_swap, 17);

    // ---- 6: clear_done never arrives ----
    do_reset();
    clear_done = 1'b0; draw_done = 1'b0;
    b_swap = n_swap;
    tick_pulse(1);
    wait_for("t6_clear", 0, 10);
`ifdef FRAME_TIMEOUT_EN
    c = 0;
    while (clear_req && c < 100) begin
      c++;
      @(negedge clk_50mhz);
    end
    check("t6_clear_cycles", c, 16);
    check("t6_timeout", timeout, 1);
    check("t6_busy", busy, 0);
    check("t6_frame_cnt", frame_cnt, 0);
    check("t6_swaps", n_swap - b_swap, 0);
`else
    c = 0;
    repeat (40) @(negedge clk_50mhz);
    check("t6_clear_held", clear_req, 1);
    check("t6_timeout_zero", timeout, 0);
    check("t6_busy", busy, 1);
    check("t6_swaps", n_swap - b_swap + c, 0);
`endif
    clear_done = 1'b1; draw_done = 1'b1;
    repeat (6) @(negedge clk_50mhz);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
